// File: rtl/adc_rd_pkg.sv
// Shared types and constants for the ping-pong BRAM reader: FSM states,
// half size and the layout of the optional frame header word.
package adc_rd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        IRQ   = 2'd3
    } rd_state_e;

    localparam int unsigned HALF_WORDS = 32768;

    localparam logic [15:0] HDR_TAG     = 16'hADC0;
    localparam int          HDR_TAG_LSB = 48;
    localparam int          HDR_CNT_LSB = 32;
    localparam int          HDR_LEN_LSB = 0;

    function automatic logic [63:0] hdr_word(input logic [15:0] cnt, input logic [31:0] len);
        logic [63:0] w;
        w                      = '0;
        w[HDR_TAG_LSB +: 16]   = HDR_TAG;
        w[HDR_CNT_LSB +: 16]   = cnt;
        w[HDR_LEN_LSB +: 32]   = len;
        return w;
    endfunction

endpackage

// File: rtl/adc_pingpong_reader_skid_fifo.sv
// Two-entry FIFO holding {last, data}; absorbs the BRAM read latency when
// the stream consumer stalls. Storage is not reset, only the pointers are.
module adc_skid_fifo #(
    parameter int W = 65
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full,
    output logic [1:0]   count
);

    logic [W-1:0] mem_q [2];
    logic [W-1:0] mem_d [2];
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   count_q, count_d;
    logic         do_push, do_pop;

    always_comb begin
        do_pop   = pop && (count_q != 2'd0);
        // A push into a full FIFO is accepted only when an entry leaves the same cycle.
        do_push  = push && ((count_q != 2'd2) || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign empty = (count_q == 2'd0);
    assign full  = (count_q == 2'd2);
    assign count = count_q;

endmodule

// File: rtl/adc_pingpong_reader.sv
// Reads the completed half of the ADC ping-pong BRAM and streams it out.
// reset is asynchronous active-low. Define ADC_RD_HDR_EN to prefix each frame with a header word.
module adc_pingpong_reader
    import adc_rd_pkg::*;
#(
    parameter int ADDR_W = $clog2(HALF_WORDS) + 1,
    parameter int DATA_W = 64,
    parameter int LEN_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic [ADDR_W-1:0] wr_addr,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_en,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              done_irq,
    output logic              busy,
    output logic              overrun,
    output logic [15:0]       frame_cnt
);

    localparam int               FW       = DATA_W + 1;
    localparam logic [LEN_W-1:0] HALF_LEN = LEN_W'(1) << (ADDR_W - 1);

    rd_state_e         state_q, state_d;
    logic              wr_msb_q, wr_msb_d;
    logic              half_q, half_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              vld_p1_q, vld_p1_d;
    logic              last_p1_q, last_p1_d;
    logic              overrun_q, overrun_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;

    logic              launch;
    logic [LEN_W-1:0]  len_launch;
    logic              idx_is_last;
    logic              can_issue;

    logic              fifo_push, fifo_pop, fifo_empty, fifo_full;
    logic [1:0]        fifo_count;
    logic [FW-1:0]     fifo_din, fifo_head;
    logic [FW-1:0]     rd_word, stream_word;
    logic              rd_push, hdr_push, out_fire;

    assign wr_msb_d    = wr_addr[ADDR_W-1];
    assign launch      = (wr_addr[ADDR_W-1] != wr_msb_q) && (cfg_len != '0);
    assign len_launch  = (cfg_len > HALF_LEN) ? HALF_LEN : cfg_len;
    assign idx_is_last = (LEN_W'(idx_q) == (len_q - LEN_W'(1)));
    assign can_issue   = !fifo_full && (({1'b0, fifo_count} + {2'b00, vld_p1_q}) < 3'd2);

    // Stage p1: BRAM data returns; bypass the FIFO when it is empty and the consumer is ready.
    assign rd_word     = {last_p1_q, rd_data};
    assign out_valid   = !fifo_empty || vld_p1_q;
    assign stream_word = fifo_empty ? rd_word : fifo_head;
    assign out_data    = out_valid ? stream_word[DATA_W-1:0] : '0;
    assign out_last    = out_valid && stream_word[DATA_W];
    assign out_fire    = out_valid && out_ready;
    assign fifo_pop    = out_fire && !fifo_empty;
    assign rd_push     = vld_p1_q && !(fifo_empty && out_ready);

`ifdef ADC_RD_HDR_EN
    assign hdr_push = (state_q == IDLE) && launch;
    assign fifo_din = hdr_push ? {1'b0, DATA_W'(hdr_word(frame_cnt_q, 32'(len_launch)))} : rd_word;
`else
    assign hdr_push = 1'b0;
    assign fifo_din = rd_word;
`endif

    assign fifo_push = rd_push || hdr_push;

    adc_skid_fifo #(
        .W (FW)
    ) u_skid (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .din   (fifo_din),
        .pop   (fifo_pop),
        .dout  (fifo_head),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    always_comb begin
        state_d     = state_q;
        half_d      = half_q;
        len_d       = len_q;
        idx_d       = idx_q;
        frame_cnt_d = frame_cnt_q;
        rd_en       = 1'b0;
        done_irq    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (launch) begin
                    state_d = READ;
                    half_d  = wr_msb_q;
                    len_d   = len_launch;
                    idx_d   = '0;
                end
            end
            READ: begin
                if (can_issue) begin
                    rd_en = 1'b1;
                    idx_d = idx_q + ADDR_W'(1);
                    if (idx_is_last) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // The tagged word is the newest one, so its acceptance empties the pipeline.
                if (out_fire && out_last) begin
                    state_d = IRQ;
                end
            end
            IRQ: begin
                done_irq    = 1'b1;
                frame_cnt_d = frame_cnt_q + 16'd1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign vld_p1_d  = rd_en;
    assign last_p1_d = rd_en && idx_is_last;
    assign overrun_d = overrun_q || (launch && (state_q != IDLE));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            wr_msb_q    <= 1'b0;
            half_q      <= 1'b0;
            len_q       <= '0;
            idx_q       <= '0;
            vld_p1_q    <= 1'b0;
            last_p1_q   <= 1'b0;
            overrun_q   <= 1'b0;
            frame_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            wr_msb_q    <= wr_msb_d;
            half_q      <= half_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            vld_p1_q    <= vld_p1_d;
            last_p1_q   <= last_p1_d;
            overrun_q   <= overrun_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign rd_addr   = {half_q, idx_q[ADDR_W-2:0]};
    assign busy      = (state_q == READ) || (state_q == DRAIN);
    assign overrun   = overrun_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_adc_pingpong_reader.sv
// Directed bench for adc_pingpong_reader: a BRAM model returns a known pattern per
// address, and each scenario task checks addresses, stream words, timing and flags.
module tb_adc_pingpong_reader;

`ifdef ADC_RD_HDR_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] cfg_len;
    logic [15:0] wr_addr;
    logic [15:0] rd_addr;
    logic        rd_en;
    logic [63:0] rd_data;
    logic [63:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        done_irq;
    logic        busy;
    logic        overrun;
    logic [15:0] frame_cnt;

    always #5 clk = ~clk;

    adc_pingpong_reader dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_len   (cfg_len),
        .wr_addr   (wr_addr),
        .rd_addr   (rd_addr),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .done_irq  (done_irq),
        .busy      (busy),
        .overrun   (overrun),
        .frame_cnt (frame_cnt)
    );

    int          vecs = 0;
    int          errs = 0;
    int          cyc  = 0;
    logic [63:0] cap_data [$];
    logic        cap_last [$];
    logic [15:0] cap_addr [$];
    int          irq_cnt, irq_cyc, first_rd, first_vld, last_vld;
    logic        pend_rd;
    logic [15:0] pend_addr;
    logic        stall_pend;
    logic [63:0] stall_data;
    logic        stall_last;
    logic [15:0] wr_v;
    int          rdy_mode;

    function automatic logic [63:0] pat(input logic [15:0] a);
        return {a, a ^ 16'h5A5A, ~a, a + 16'h1111};
    endfunction

    function automatic int bad_addrs(input logic [15:0] base, input int n);
        int bad = 0;
        if (cap_addr.size() != n) return -1;
        for (int i = 0; i < n; i++)
            if (cap_addr[i] !== base + 16'(i)) bad++;
        return bad;
    endfunction

    function automatic int bad_words(input logic [15:0] base, input int n,
                                     input logic [15:0] hcnt, input logic [31:0] hlen);
        int bad = 0;
        if (cap_data.size() != n + HDR) return -1;
        if (HDR == 1) begin
            if (cap_data[0] !== {16'hADC0, hcnt, hlen}) bad++;
            if (cap_last[0] !== 1'b0) bad++;
        end
        for (int i = 0; i < n; i++) begin
            if (cap_data[i + HDR] !== pat(base + 16'(i))) bad++;
            if (cap_last[i + HDR] !== (i == n - 1)) bad++;
        end
        return bad;
    endfunction

    task automatic clear_caps();
        cap_data.delete();
        cap_last.delete();
        cap_addr.delete();
        irq_cnt   = 0;
        irq_cyc   = -1;
        first_rd  = -1;
        first_vld = -1;
        last_vld  = -1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        wr_addr = wr_v;
        rd_data = pend_rd ? pat(pend_addr) : 64'h0;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ~out_ready;
            default: out_ready = 1'b0;
        endcase
        @(negedge clk);
        cyc++;
        if (stall_pend) begin
            vecs++;
            if ({out_valid, out_data, out_last} !== {1'b1, stall_data, stall_last}) begin
                errs++;
                $display("FAIL stall_hold: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                         out_valid, out_data, out_last, stall_data, stall_last);
            end
        end
        stall_pend = out_valid && !out_ready;
        stall_data = out_data;
        stall_last = out_last;
        pend_rd    = rd_en;
        pend_addr  = rd_addr;
        if (rd_en) begin
            cap_addr.push_back(rd_addr);
            if (first_rd < 0) first_rd = cyc;
        end
        if (out_valid && out_ready) begin
            cap_data.push_back(out_data);
            cap_last.push_back(out_last);
            if (first_vld < 0) first_vld = cyc;
            last_vld = cyc;
        end
        if (done_irq) begin
            irq_cnt++;
            irq_cyc = cyc;
        end
    endtask

    task automatic run_until_irq(input string name, input int budget);
        int start;
        int n;
        start = irq_cnt;
        n     = 0;
        while (irq_cnt == start && n < budget) begin
            tick();
            n++;
        end
        vecs++;
        if (irq_cnt == start) begin
            errs++;
            $display("FAIL %s_irq_timeout: got no done_irq in %0d cycles, want one", name, budget);
        end
    endtask

    task automatic test_reset();
        reset      = 1'b0;
        cfg_len    = 32'd0;
        wr_addr    = 16'h0000;
        wr_v       = 16'h0000;
        rd_data    = 64'h0;
        out_ready  = 1'b1;
        rdy_mode   = 0;
        pend_rd    = 1'b0;
        pend_addr  = 16'h0;
        stall_pend = 1'b0;
        clear_caps();
        repeat (2) @(negedge clk);
        vecs++;
        if ({out_valid, rd_en, busy, done_irq, overrun, out_last, frame_cnt, out_data, rd_addr} !== '0) begin
            errs++;
            $display("FAIL reset_outputs: got v=%b en=%b busy=%b irq=%b ovr=%b last=%b cnt=%0d d=%h a=%h want all 0",
                     out_valid, rd_en, busy, done_irq, overrun, out_last, frame_cnt, out_data, rd_addr);
        end
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        vecs++;
        if ({busy, out_valid, rd_en, frame_cnt} !== '0) begin
            errs++;
            $display("FAIL reset_release_idle: got busy=%b v=%b en=%b cnt=%0d want 0",
                     busy, out_valid, rd_en, frame_cnt);
        end
    endtask

    task automatic test_basic();
        int lc;
        int b;
        clear_caps();
        cfg_len  = 32'd8;
        rdy_mode = 0;
        wr_v     = 16'h0007;
        repeat (3) tick();
        wr_v = 16'h8000;
        tick();
        lc = cyc;
        run_until_irq("basic", 200);
        b = bad_addrs(16'h0000, 8);
        vecs++;
        if (b !== 0) begin errs++; $display("FAIL basic_addrs: got %0d bad, want 0", b); end
        b = bad_words(16'h0000, 8, 16'd0, 32'd8);
        vecs++;
        if (b !== 0) begin errs++; $display("FAIL basic_words: got %0d bad, want 0", b); end
        vecs++;
        if (first_rd !== lc + 1) begin
            errs++; $display("FAIL basic_rd_latency: got cycle %0d want %0d", first_rd, lc + 1);
        end
        vecs++;
        if (first_vld !== lc + 2 - HDR) begin
            errs++; $display("FAIL basic_first_word: got cycle %0d want %0d", first_vld, lc + 2 - HDR);
        end
        vecs++;
        if (last_vld - first_vld !== 7 + HDR) begin
            errs++; $display("FAIL basic_throughput: got span %0d want %0d", last_vld - first_vld, 7 + HDR);
        end
        vecs++;
        if (irq_cyc !== last_vld + 1) begin
            errs++; $display("FAIL basic_irq_timing: got cycle %0d want %0d", irq_cyc, last_vld + 1);
        end
        tick();
        vecs++;
        if ({frame_cnt, busy, done_irq} !== {16'd1, 1'b0, 1'b0}) begin
            errs++; $display("FAIL basic_after: got cnt=%0d busy=%b irq=%b want cnt=1 busy=0 irq=0",
                             frame_cnt, busy, done_irq);
        end
    endtask

    task automatic test_toggle_ready();
        int b;
        clear_caps();
        cfg_len  = 32'd4;
        rdy_mode = 1;
        wr_v     = 16'h8003;
        repeat (2) tick();
        wr_v = 16'h0000;
        tick();
        tick();
        cfg_len = 32'd0;
        run_until_irq("toggle", 100);
        b = bad_addrs(16'h8000, 4);
        vecs++;
        if (b !== 0) begin errs++; $display("FAIL toggle_addrs: got %0d bad, want 0", b); end
        b = bad_words(16'h8000, 4, 16'd1, 32'd4);
        vecs++;
        if (b !== 0) begin errs++; $display("FAIL toggle_words: got %0d bad, want 0", b); end
        tick();
        vecs++;
        if (frame_cnt !== 16'd2) begin
            errs++; $display("FAIL toggle_frame_cnt: got %0d want 2", frame_cnt);
        end
    endtask

    task automatic test_clamp();
        int b;
        clear_caps();
        cfg_len  = 32'd40000;
        rdy_mode = 0;
        wr_v     = 16'h7FFF;
        repeat (2) tick();
        wr_v = 16'h8000;
        tick();
        run_until_irq("clamp", 33000);
        vecs++;
        if (cap_addr.size() !== 32768) begin
            errs++; $display("FAIL clamp_count: got %0d reads want 32768", cap_addr.size());
        end
        vecs++;
        if (cap_addr.size() == 0 || cap_addr[cap_addr.size() - 1] !== 16'h7FFF) begin
            errs++; $display("FAIL clamp_last_addr: got %h want 7fff",
                             (cap_addr.size() == 0) ? 16'hxxxx : cap_addr[cap_addr.size() - 1]);
        end
        b = bad_words(16'h0000, 32768, 16'd2, 32'd32768);
        vecs++;
        if (b !== 0) begin errs++; $display("FAIL clamp_words: got %0d bad, want 0", b); end
        tick();
        vecs++;
        if ({frame_cnt, overrun} !== {16'd3, 1'b0}) begin
            errs++; $display("FAIL clamp_after: got cnt=%0d ovr=%b want cnt=3 ovr=0", frame_cnt, overrun);
        end
    endtask

    task automatic test_overrun();
        int b;
        clear_caps();
        cfg_len  = 32'd8;
        rdy_mode = 2;
        wr_v     = 16'h0000;
        tick();
        repeat (4) tick();
        vecs++;
        if ({busy, overrun} !== 2'b10 || cap_data.size() !== 0) begin
            errs++; $display("FAIL ovr_stalled: got busy=%b ovr=%b words=%0d want busy=1 ovr=0 words=0",
                             busy, overrun, cap_data.size());
        end
        wr_v = 16'h8000;
        tick();
        tick();
        vecs++;
        if (overrun !== 1'b1) begin errs++; $display("FAIL ovr_flag: got %b want 1", overrun); end
        rdy_mode = 0;
        run_until_irq("ovr", 100);
        repeat (20) tick();
        vecs++;
        if (irq_cnt !== 1) begin errs++; $display("FAIL ovr_irq_count: got %0d want 1", irq_cnt); end
        b = bad_addrs(16'h8000, 8);
        vecs++;
        if (b !== 0) begin errs++; $display("FAIL ovr_addrs: got %0d bad, want 0", b); end
        b = bad_words(16'h8000, 8, 16'd3, 32'd8);
        vecs++;
        if (b !== 0) begin errs++; $display("FAIL ovr_words: got %0d bad, want 0", b); end
        vecs++;
        if ({busy, overrun, frame_cnt} !== {1'b0, 1'b1, 16'd4}) begin
            errs++; $display("FAIL ovr_after: got busy=%b ovr=%b cnt=%0d want busy=0 ovr=1 cnt=4",
                             busy, overrun, frame_cnt);
        end
    endtask

    task automatic test_reset_mid_frame();
        int n;
        int b;
        clear_caps();
        cfg_len  = 32'd8;
        rdy_mode = 0;
        wr_v     = 16'h0000;
        tick();
        n = 0;
        while (cap_data.size() < 3 + HDR && n < 50) begin
            tick();
            n++;
        end
        vecs++;
        if (cap_data.size() !== 3 + HDR) begin
            errs++; $display("FAIL rstmid_progress: got %0d words want %0d", cap_data.size(), 3 + HDR);
        end
        #2 reset = 1'b0;
        #1;
        vecs++;
        if ({out_valid, rd_en, busy, done_irq, overrun, out_last, frame_cnt, out_data, rd_addr} !== '0) begin
            errs++;
            $display("FAIL rstmid_outputs: got v=%b en=%b busy=%b irq=%b ovr=%b last=%b cnt=%0d d=%h a=%h want all 0",
                     out_valid, rd_en, busy, done_irq, overrun, out_last, frame_cnt, out_data, rd_addr);
        end
        pend_rd    = 1'b0;
        stall_pend = 1'b0;
        @(posedge clk);
        #1;
        reset   = 1'b1;
        rd_data = 64'h0;
        clear_caps();
        repeat (3) tick();
        vecs++;
        if (cap_addr.size() !== 0 || busy !== 1'b0) begin
            errs++; $display("FAIL rstmid_quiet: got reads=%0d busy=%b want 0 0", cap_addr.size(), busy);
        end
        wr_v = 16'h8000;
        tick();
        run_until_irq("rstmid", 100);
        b = bad_addrs(16'h0000, 8);
        vecs++;
        if (b !== 0) begin errs++; $display("FAIL rstmid_addrs: got %0d bad, want 0", b); end
        b = bad_words(16'h0000, 8, 16'd0, 32'd8);
        vecs++;
        if (b !== 0) begin errs++; $display("FAIL rstmid_words: got %0d bad, want 0", b); end
        tick();
        vecs++;
        if (frame_cnt !== 16'd1) begin errs++; $display("FAIL rstmid_frame_cnt: got %0d want 1", frame_cnt); end
    endtask

    task automatic test_len_zero();
        clear_caps();
        cfg_len  = 32'd0;
        rdy_mode = 0;
        wr_v     = 16'h0000;
        repeat (10) tick();
        vecs++;
        if (cap_addr.size() !== 0 || irq_cnt !== 0 || busy !== 1'b0) begin
            errs++; $display("FAIL len_zero: got reads=%0d irqs=%0d busy=%b want 0 0 0",
                             cap_addr.size(), irq_cnt, busy);
        end
    endtask

`ifdef ADC_RD_HDR_EN
    task automatic test_header();
        int b;
        clear_caps();
        cfg_len  = 32'd2;
        rdy_mode = 0;
        wr_v     = 16'h8000;
        tick();
        run_until_irq("hdr", 100);
        vecs++;
        if (cap_data.size() !== 3 || cap_data[0] !== {16'hADC0, 16'd1, 32'd2}) begin
            errs++; $display("FAIL hdr_word: got n=%0d w0=%h want n=3 w0=adc0000100000002",
                             cap_data.size(), (cap_data.size() > 0) ? cap_data[0] : 64'hx);
        end
        b = bad_words(16'h0000, 2, 16'd1, 32'd2);
        vecs++;
        if (b !== 0) begin errs++; $display("FAIL hdr_words: got %0d bad, want 0", b); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_toggle_ready();
        test_clamp();
        test_overrun();
        test_reset_mid_frame();
        test_len_zero();
`ifdef ADC_RD_HDR_EN
        test_header();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
